// File: rtl/buzzer_scheduler_if.sv
// Request/response bundle between the clock controller, key logic and the buzzer scheduler.
// The scheduler sits on the slave side; the requesting logic sits on the master side.
interface buzzer_scheduler_if;
    logic       tick_ms;
    logic       alarm_req;
    logic       chime_req;
    logic       click_req;
    logic       buzzer_en;
    logic       busy;
    logic [1:0] active_src;
    logic       alarm_timeout;

    modport master (
        output tick_ms, alarm_req, chime_req, click_req,
        input  buzzer_en, busy, active_src, alarm_timeout
    );

    modport slave (
        input  tick_ms, alarm_req, chime_req, click_req,
        output buzzer_en, busy, active_src, alarm_timeout
    );
endinterface

// File: rtl/buzzer_scheduler.sv
// Shares one buzzer between alarm, hourly chime and key click by fixed priority,
// turning each granted request into a beep pattern timed by the 1 ms tick.
module buzzer_scheduler #(
    parameter int ALARM_ON_MS     = 250,
    parameter int ALARM_OFF_MS    = 250,
    parameter int ALARM_MAX_BEEPS = 120,
    parameter int CHIME_ON_MS     = 100,
    parameter int CHIME_OFF_MS    = 100,
    parameter int CHIME_BEEPS     = 2,
    parameter int CLICK_MS        = 30
) (
    input  logic               clk,
    input  logic               rst,
    buzzer_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ALM_ON  = 3'd1,
        S_ALM_OFF = 3'd2,
        S_CHM_ON  = 3'd3,
        S_CHM_OFF = 3'd4,
        S_CLICK   = 3'd5
    } state_t;

    localparam logic [15:0] ALM_ON_LAST  = 16'(ALARM_ON_MS - 1);
    localparam logic [15:0] ALM_OFF_LAST = 16'(ALARM_OFF_MS - 1);
    localparam logic [15:0] ALM_BEEP_LAST = 16'(ALARM_MAX_BEEPS - 1);
    localparam logic [15:0] CHM_ON_LAST  = 16'(CHIME_ON_MS - 1);
    localparam logic [15:0] CHM_OFF_LAST = 16'(CHIME_OFF_MS - 1);
    localparam logic [15:0] CHM_BEEP_LAST = 16'(CHIME_BEEPS - 1);
    localparam logic [15:0] CLICK_LAST   = 16'(CLICK_MS - 1);

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] alm_beeps_q, alm_beeps_d;
    logic [15:0] chm_beeps_q, chm_beeps_d;
    logic        chime_prev_q, chime_prev_d;
    logic        chime_pend_q, chime_pend_d;
    logic        click_pend_q, click_pend_d;
    logic        mute_q, mute_d;
    logic        buzzer_q, buzzer_d;
    logic        busy_q, busy_d;
    logic [1:0]  src_q, src_d;
    logic        timeout_q, timeout_d;

    logic        alarm_eff, chime_set, click_set, chime_avail, click_avail;
    logic        chime_take, click_take, phase_end;
    logic [15:0] phase_last;

    always_comb begin
        alarm_eff   = bus.alarm_req & ~mute_q;
        chime_set   = bus.chime_req & ~chime_prev_q &
                      ~((state_q == S_CHM_ON) || (state_q == S_CHM_OFF));
        click_set   = bus.click_req & (state_q != S_CLICK);
        chime_avail = chime_pend_q | chime_set;
        click_avail = click_pend_q | click_set;

        case (state_q)
            S_ALM_ON:  phase_last = ALM_ON_LAST;
            S_ALM_OFF: phase_last = ALM_OFF_LAST;
            S_CHM_ON:  phase_last = CHM_ON_LAST;
            S_CHM_OFF: phase_last = CHM_OFF_LAST;
            S_CLICK:   phase_last = CLICK_LAST;
            default:   phase_last = 16'd0;
        endcase
        phase_end = bus.tick_ms && (phase_q == phase_last);

        state_d     = state_q;
        alm_beeps_d = alm_beeps_q;
        chm_beeps_d = chm_beeps_q;
        timeout_d   = 1'b0;
        chime_take  = 1'b0;
        click_take  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (alarm_eff) begin
                    state_d     = S_ALM_ON;
                    alm_beeps_d = 16'd0;
                end else if (chime_avail) begin
                    state_d     = S_CHM_ON;
                    chm_beeps_d = 16'd0;
                    chime_take  = 1'b1;
                end else if (click_avail) begin
                    state_d    = S_CLICK;
                    click_take = 1'b1;
                end
            end
            S_ALM_ON: begin
                if (!alarm_eff)     state_d = S_IDLE;
                else if (phase_end) state_d = S_ALM_OFF;
            end
            S_ALM_OFF: begin
                if (!alarm_eff) begin
                    state_d = S_IDLE;
                end else if (phase_end) begin
                    if (alm_beeps_q == ALM_BEEP_LAST) begin
                        state_d   = S_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d     = S_ALM_ON;
                        alm_beeps_d = alm_beeps_q + 16'd1;
                    end
                end
            end
            S_CHM_ON, S_CHM_OFF, S_CLICK: begin
                // Alarm preemption discards the running chime/click for good.
                if (alarm_eff) begin
                    state_d     = S_ALM_ON;
                    alm_beeps_d = 16'd0;
                end else if (phase_end) begin
                    if (state_q == S_CLICK) begin
                        state_d = S_IDLE;
                    end else if (state_q == S_CHM_OFF) begin
                        state_d = S_CHM_ON;
                    end else if (chm_beeps_q == CHM_BEEP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_CHM_OFF;
                        chm_beeps_d = chm_beeps_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Entering a pattern consumes its request; a fresh request on top of an old one survives.
        chime_pend_d = chime_take ? (chime_pend_q & chime_set) : chime_avail;
        click_pend_d = click_take ? (click_pend_q & click_set) : click_avail;
        mute_d       = timeout_d | (mute_q & bus.alarm_req);
        chime_prev_d = bus.chime_req;
        phase_d      = (state_d != state_q) ? 16'd0 : phase_q + 16'(bus.tick_ms);

        buzzer_d = (state_d == S_ALM_ON) || (state_d == S_CHM_ON) || (state_d == S_CLICK);
        busy_d   = (state_d != S_IDLE);
        case (state_d)
            S_ALM_ON, S_ALM_OFF: src_d = 2'd1;
            S_CHM_ON, S_CHM_OFF: src_d = 2'd2;
            S_CLICK:             src_d = 2'd3;
            default:             src_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            phase_q      <= 16'd0;
            alm_beeps_q  <= 16'd0;
            chm_beeps_q  <= 16'd0;
            chime_prev_q <= 1'b0;
            chime_pend_q <= 1'b0;
            click_pend_q <= 1'b0;
            mute_q       <= 1'b0;
            buzzer_q     <= 1'b0;
            busy_q       <= 1'b0;
            src_q        <= 2'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            alm_beeps_q  <= alm_beeps_d;
            chm_beeps_q  <= chm_beeps_d;
            chime_prev_q <= chime_prev_d;
            chime_pend_q <= chime_pend_d;
            click_pend_q <= click_pend_d;
            mute_q       <= mute_d;
            buzzer_q     <= buzzer_d;
            busy_q       <= busy_d;
            src_q        <= src_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.buzzer_en     = buzzer_q;
    assign bus.busy          = busy_q;
    assign bus.active_src    = src_q;
    assign bus.alarm_timeout = timeout_q;
endmodule
